// File: rtl/sign_narrow_16to6.sv
// sign_narrow_16to6: narrows 16-bit two's-complement words to 6-bit signed
// immediates, flags out-of-range words, and buffers results in a small
// valid/ready output FIFO.
// Optional build macro: SIGN_NARROW_SATURATE_EN. When defined, an out-of-range
// word is clamped to -32/+31. Otherwise it is truncated to its low 6 bits.
module sign_narrow_16to6 #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_data,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         ovf_count,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned ENT_W  = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Each FIFO entry is {ovf, data[5:0]}
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fits_c;
    logic [5:0]        narrow_c;
    logic              push_c;
    logic              pop_c;
    logic [ENT_W-1:0]  head_c;

    // Range check and narrowing of the incoming word
    always_comb begin
        fits_c   = (&in_data[15:5]) | ~(|in_data[15:5]);
        narrow_c = in_data[5:0];
`ifdef SIGN_NARROW_SATURATE_EN
        if (!fits_c) begin
            narrow_c = in_data[15] ? 6'b10_0000 : 6'b01_1111;
        end
`endif
    end

    // Handshake status derived from registered occupancy only
    always_comb begin
        in_ready  = (fill_q != FILL_W'(DEPTH));
        out_valid = (fill_q != FILL_W'(0));
        push_c    = in_valid && in_ready;
        pop_c     = out_valid && out_ready;
        head_c    = mem_q[rptr_q];
        out_data  = out_valid ? head_c[5:0] : 6'd0;
        out_ovf   = out_valid ? head_c[6]   : 1'b0;
        ovf_count = cnt_q;
        fill      = fill_q;
    end

    // Next-state for pointers, occupancy and the overflow counter
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        if (push_c) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        // Clear takes effect first, so a same-cycle overflow still counts once
        if (ovf_clr) begin
            cnt_d = (push_c && !fits_c) ? CNT_W'(1) : CNT_W'(0);
        end else if (push_c && !fits_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage, written at the tail on an accepted word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wptr_q] <= {~fits_c, narrow_c};
        end
    end

endmodule
